// File: rtl/acum_drain_pkg.sv
// Shared types and constants for the accumulator drain block.
// The ACUM_DRAIN_RELU_EN build option uses relu_lane() from this package.
package acum_drain_pkg;

  localparam int LANES  = 4;
  localparam int LANE_W = 32;
  localparam int ROW_DW = 128;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_CAPTURE,
    ST_WRITE,
    ST_DONE
  } drain_state_t;

  function automatic logic [LANE_W-1:0] relu_lane(input logic [LANE_W-1:0] v);
    return v[LANE_W-1] ? '0 : v;
  endfunction

endpackage

// File: rtl/acum_drain_post.sv
// Per-lane row transform applied as a FIFO word is captured.
// ACUM_DRAIN_RELU_EN selects signed ReLU per lane; without it the row passes through.
module drain_post
  import acum_drain_pkg::*;
(
  input  logic [ROW_DW-1:0] row_i,
  output logic [ROW_DW-1:0] row_o
);

`ifdef ACUM_DRAIN_RELU_EN
  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign row_o[i*LANE_W +: LANE_W] = relu_lane(row_i[i*LANE_W +: LANE_W]);
  end
`else
  assign row_o = row_i;
`endif

endmodule

// File: rtl/acum_drain.sv
// Drains result rows from the accumulator output FIFO to memory, one row per
// write, addresses spaced by a programmable stride. Build option: ACUM_DRAIN_RELU_EN.
//
// state   | meaning
// IDLE    | waiting for start
// ISSUE   | pop one word once the FIFO is non-empty
// CAPTURE | FIFO data valid this cycle; register transformed row
// WRITE   | hold write request until accepted
// DONE    | one-cycle done pulse
module acum_drain
  import acum_drain_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int ROW_W  = 5
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              start_i,
  input  logic [ADDR_W-1:0] base_addr_i,
  input  logic [ADDR_W-1:0] stride_i,
  input  logic [ROW_W-1:0]  num_rows_i,
  output logic              busy_o,
  output logic              done_o,
  input  logic              buf_empty_i,
  output logic              buf_rd_en_o,
  input  logic [ROW_DW-1:0] buf_data_i,
  output logic              mem_wr_valid_o,
  input  logic              mem_wr_ready_i,
  output logic [ADDR_W-1:0] mem_wr_addr_o,
  output logic [ROW_DW-1:0] mem_wr_data_o
);

  drain_state_t      state_q;
  logic              busy_q;
  logic              done_q;
  logic              valid_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W-1:0] stride_q;
  logic [ROW_W-1:0]  rows_q;
  logic [ROW_W-1:0]  row_cnt_q;
  logic [ROW_W-1:0]  row_cnt_d;
  logic [ROW_DW-1:0] data_q;
  logic [ROW_DW-1:0] post_row;

  drain_post u_post (
    .row_i (buf_data_i),
    .row_o (post_row)
  );

  assign row_cnt_d = row_cnt_q + ROW_W'(1);

  // Pop is qualified by the live empty flag so a stale sample can never underflow the FIFO.
  assign buf_rd_en_o = (state_q == ST_ISSUE) && !buf_empty_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      valid_q   <= 1'b0;
      addr_q    <= '0;
      stride_q  <= '0;
      rows_q    <= '0;
      row_cnt_q <= '0;
      data_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start_i) begin
            busy_q <= 1'b1;
            if (num_rows_i != '0) begin
              rows_q    <= num_rows_i;
              stride_q  <= stride_i;
              addr_q    <= base_addr_i;
              row_cnt_q <= '0;
              state_q   <= ST_ISSUE;
            end else begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end
          end
        end
        ST_ISSUE: begin
          if (!buf_empty_i) state_q <= ST_CAPTURE;
        end
        ST_CAPTURE: begin
          data_q  <= post_row;
          valid_q <= 1'b1;
          state_q <= ST_WRITE;
        end
        ST_WRITE: begin
          if (mem_wr_ready_i) begin
            valid_q   <= 1'b0;
            row_cnt_q <= row_cnt_d;
            addr_q    <= addr_q + stride_q;
            if (row_cnt_d == rows_q) begin
              done_q  <= 1'b1;
              state_q <= ST_DONE;
            end else begin
              state_q <= ST_ISSUE;
            end
          end
        end
        ST_DONE: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign mem_wr_valid_o = valid_q;
  assign mem_wr_addr_o  = addr_q;
  assign mem_wr_data_o  = data_q;

endmodule

// File: tb/tb_acum_drain.sv
// Scoreboard bench for acum_drain: FIFO model, randomized rows and ready stalls,
// expected writes derived from base + k*stride and the lane transform.
module tb_acum_drain;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [31:0]  base_addr = '0;
  logic [31:0]  stride = '0;
  logic [4:0]   num_rows = '0;
  logic         busy, done;
  logic         buf_empty = 1'b1;
  logic         buf_rd_en;
  logic [127:0] buf_data = '0;
  logic         mem_wr_valid;
  logic         mem_wr_ready = 1'b1;
  logic [31:0]  mem_wr_addr;
  logic [127:0] mem_wr_data;

  always #5 clk = ~clk;

  acum_drain dut (
    .clk_i          (clk),
    .rst_ni         (rst_n),
    .start_i        (start),
    .base_addr_i    (base_addr),
    .stride_i       (stride),
    .num_rows_i     (num_rows),
    .busy_o         (busy),
    .done_o         (done),
    .buf_empty_i    (buf_empty),
    .buf_rd_en_o    (buf_rd_en),
    .buf_data_i     (buf_data),
    .mem_wr_valid_o (mem_wr_valid),
    .mem_wr_ready_i (mem_wr_ready),
    .mem_wr_addr_o  (mem_wr_addr),
    .mem_wr_data_o  (mem_wr_data)
  );

  typedef struct {
    logic [31:0]  addr;
    logic [127:0] data;
  } wr_t;

  int n_cmp = 0;
  int n_bad = 0;
  wr_t exp_q[$];
  logic [127:0] fifo[$];
  logic [127:0] run_words[$];
  logic         push_req = 1'b0;
  logic [127:0] push_data = '0;
  logic         fifo_flush = 1'b0;
  int pops = 0;
  int run_id = 0;
  int hs_run = 0;
  int stall_row = -1;
  int stall_len = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected row as written to memory: lanes are signed values, clamped at zero under ReLU.
  function automatic logic [127:0] expect_row(input logic [127:0] r);
    logic [127:0] res;
    int lane;
    for (int i = 0; i < 4; i++) begin
      lane = int'(r[32*i +: 32]);
`ifdef ACUM_DRAIN_RELU_EN
      if (lane < 0) lane = 0;
`endif
      res[32*i +: 32] = lane;
    end
    return res;
  endfunction

  // FIFO model: data appears one cycle after rd_en
  always @(posedge clk) begin
    if (buf_rd_en) begin
      chk("pop_while_empty", fifo.size() == 0, 0);
      if (fifo.size() != 0) buf_data <= fifo.pop_front();
      pops++;
    end
    if (fifo_flush) fifo.delete();
    if (push_req) fifo.push_back(push_data);
    buf_empty <= (fifo.size() == 0);
  end

  int rdy_id = 0;
  int stall_cnt = 0;
  always @(posedge clk) begin
    #1;
    if (run_id != rdy_id) begin
      rdy_id = run_id;
      stall_cnt = 0;
    end
    if (mem_wr_valid && hs_run == stall_row && stall_cnt < stall_len) begin
      mem_wr_ready = 1'b0;
      stall_cnt++;
    end else begin
      mem_wr_ready = 1'b1;
    end
  end

  int mon_id = 0;
  bit held = 0;
  logic [31:0]  held_a;
  logic [127:0] held_d;
  always @(negedge clk) begin
    wr_t e;
    if (run_id != mon_id) begin
      mon_id = run_id;
      hs_run = 0;
    end
    if (mem_wr_valid) begin
      if (held) begin
        chk("addr_stable", mem_wr_addr, held_a);
        chk("data_stable", mem_wr_data, held_d);
      end
      if (mem_wr_ready) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_write: got addr %h data %h, expected no write", mem_wr_addr, mem_wr_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", mem_wr_addr, e.addr);
          chk("wr_data", mem_wr_data, e.data);
        end
        hs_run++;
        held = 0;
      end else begin
        held = 1;
        held_a = mem_wr_addr;
        held_d = mem_wr_data;
      end
    end else begin
      held = 0;
    end
  end

  task automatic load_words();
    foreach (run_words[i]) begin
      push_req = 1'b1;
      push_data = run_words[i];
      @(posedge clk); #1;
    end
    push_req = 1'b0;
  endtask

  task automatic issue_start(input logic [31:0] b, input logic [31:0] s, input int n);
    for (int k = 0; k < n; k++)
      exp_q.push_back('{addr: b + 32'(k) * s, data: expect_row(run_words[k])});
    base_addr = b;
    stride = s;
    num_rows = 5'(n);
    start = 1'b1;
    run_id++;
  endtask

  task automatic run(input logic [31:0] b, input logic [31:0] s, input int n,
                     input int exp_done, input bit chk_timing);
    int cyc = 0;
    bit seen = 0;
    issue_start(b, s, n);
    while (cyc < 2000 && !seen) begin
      @(posedge clk); #1;
      start = 1'b0;
      cyc++;
      @(negedge clk);
      if (chk_timing && cyc == 1) begin
        chk("busy_t1", busy, 1);
        chk("rd_en_t1", buf_rd_en, 1);
      end
      if (chk_timing && cyc == 3) chk("valid_t3", mem_wr_valid, 1);
      if (done) seen = 1;
    end
    if (!seen) begin
      n_cmp++;
      n_bad++;
      $display("FAIL done_timeout: got no done in %0d cycles, expected done", cyc);
    end else begin
      if (exp_done >= 0) chk("done_cycle", cyc, exp_done);
      chk("rows_left", exp_q.size(), 0);
      @(posedge clk); @(negedge clk);
      chk("done_pulse_end", done, 0);
      chk("busy_end", busy, 0);
    end
    exp_q.delete();
    @(posedge clk); #1;
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_rd_en"}, buf_rd_en, 0);
    chk({tag, "_valid"}, mem_wr_valid, 0);
    chk({tag, "_addr"}, mem_wr_addr, 0);
    chk({tag, "_data"}, mem_wr_data, 0);
  endtask

  task automatic basic_four();
    run_words.delete();
    for (int k = 0; k < 4; k++) run_words.push_back({$urandom, $urandom, $urandom, $urandom});
    load_words();
  endtask

  initial begin
    int p0, w, n;
    logic [127:0] word;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs("reset");
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // four rows, ready always high
    basic_four();
    run(32'h1000, 32'h10, 4, 13, 1);
    chk("fifo_empty_after", buf_empty, 1);

    // ready held low 5 cycles on row 1
    basic_four();
    stall_row = 1; stall_len = 5;
    p0 = pops;
    run(32'h1000, 32'h10, 4, 18, 0);
    chk("stall_pops", pops - p0, 4);
    stall_row = -1;

    // FIFO empty at start, one word arrives 10 cycles later
    run_words.delete();
    word = {$urandom, $urandom, $urandom, $urandom};
    run_words.push_back(word);
    fork
      run(32'h2000, 32'h40, 1, -1, 0);
      begin
        repeat (10) begin @(posedge clk); #1; end
        push_req = 1'b1;
        push_data = word;
        @(posedge clk); #1;
        push_req = 1'b0;
      end
    join

    // address wrap
    run_words.delete();
    for (int k = 0; k < 2; k++) run_words.push_back({$urandom, $urandom, $urandom, $urandom});
    load_words();
    run(32'hFFFF_FFF0, 32'h10, 2, 7, 0);

    // negative and positive lanes
    run_words.delete();
    run_words.push_back({32'd7, 32'h8000_0000, 32'd5, 32'hFFFF_FFFF});
    load_words();
    run(32'h3000, 32'h0, 1, 4, 0);

    // zero rows
    run_words.delete();
    p0 = pops;
    run(32'h4000, 32'h10, 0, 1, 0);
    chk("zero_rows_pops", pops - p0, 0);

    // reset during WRITE of row 2
    basic_four();
    stall_row = 2; stall_len = 1000;
    issue_start(32'h5000, 32'h20, 4);
    @(posedge clk); #1;
    start = 1'b0;
    w = 0;
    while (!(hs_run == 2 && mem_wr_valid) && w < 200) begin
      @(posedge clk); #1;
      w++;
    end
    chk("reach_row2_write", w < 200, 1);
    rst_n = 1'b0;
    fifo_flush = 1'b1;
    @(negedge clk);
    check_reset_outputs("abort");
    exp_q.delete();
    @(posedge clk); #1;
    fifo_flush = 1'b0;
    stall_row = -1; stall_len = 0;
    rst_n = 1'b1;
    @(posedge clk); #1;
    basic_four();
    run(32'h1000, 32'h10, 4, 13, 1);

    // randomized runs
    for (int r = 0; r < 8; r++) begin
      n = $urandom_range(1, 16);
      run_words.delete();
      for (int k = 0; k < n; k++) run_words.push_back({$urandom, $urandom, $urandom, $urandom});
      load_words();
      stall_row = $urandom_range(0, n - 1);
      stall_len = $urandom_range(0, 4);
      run($urandom, $urandom, n, 1 + 3 * n + stall_len, 0);
      stall_row = -1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/acum_drain.md
# acum_drain

Read side of the accumulator output buffer in the GEMM datapath. On a start command it pops a programmed number of 128-bit result rows (four 32-bit lanes) from the output FIFO and writes each row to memory through a valid/ready write port, one address per row spaced by a programmable byte stride. It signals completion to the GEMM controller with a one-cycle done pulse.

## Interface
- ADDR_W, 32, memory byte-address width
- ROW_W, 5, width of the row count; up to 16 rows, matching the FIFO depth
- clk  input  1  clock; all logic rising-edge
- rst  input  1  asynchronous, active-low reset
- start  input  1  one-cycle command pulse; sampled only in IDLE
- base_addr  input  ADDR_W  address of row 0; captured on start
- stride  input  ADDR_W  byte increment between rows; captured on start
- num_rows  input  ROW_W  rows to drain; captured on start
- busy  output  1  high from the cycle after an accepted start until done
- done  output  1  one-cycle pulse after the last row write is accepted
- buf_empty  input  1  output FIFO empty flag
- buf_rd_en  output  1  FIFO pop; the FIFO presents data one cycle after rd_en
- buf_data  input  128  FIFO read data; lane i is bits [32i+31:32i]
- mem_wr_valid  output  1  write request valid
- mem_wr_ready  input  1  write request accepted when valid && ready
- mem_wr_addr  output  ADDR_W  write address
- mem_wr_data  output  128  write data

## Operation
- States: IDLE, ISSUE, CAPTURE, WRITE, DONE.
- IDLE: on start with num_rows != 0, latch the parameters, clear row_cnt, addr <= base_addr, go to ISSUE. With num_rows == 0, go directly to DONE. A start outside IDLE is ignored.
- ISSUE: if !buf_empty, assert buf_rd_en for exactly one cycle and go to CAPTURE; otherwise hold in ISSUE with rd_en low.
- CAPTURE: register buf_data (after the lane transform, see Configuration) into data_q and go to WRITE.
- WRITE: hold mem_wr_valid high with stable addr/data until mem_wr_ready. On the handshake: row_cnt++, addr <= addr + stride (modulo 2^ADDR_W, wraps silently). If row_cnt+1 == num_rows, go to DONE; otherwise go to ISSUE.
- DONE: done = 1 for one cycle, then IDLE.
- buf_rd_en is never asserted while buf_empty = 1 and never outside ISSUE. At most one word is in flight.

## Timing
- Reset values: busy = 0, done = 0, buf_rd_en = 0, mem_wr_valid = 0, mem_wr_addr = 0, mem_wr_data = 0. The state machine resets to IDLE.
- Reset asserted mid-transfer aborts immediately. A popped but unwritten word is lost. No done pulse is produced.
- Start is accepted in cycle t. buf_rd_en is asserted at t+1 if the FIFO is non-empty. mem_wr_valid rises at t+3.
- Steady-state throughput with ready = 1 and a non-empty FIFO: one row per 3 cycles.
- done is asserted the cycle after the final handshake. busy falls in the same cycle done falls.
- A start with num_rows == 0 produces done at t+1.

## Configuration
- ACUM_DRAIN_RELU_EN defined: each 32-bit lane is treated as signed, and a negative lane is written as 0 (ReLU), applied in CAPTURE.
- ACUM_DRAIN_RELU_EN undefined: lanes pass through unmodified. Latency is identical in both cases.

## Structure
- Config package: typedef enum drain_state_t; constants LANES = 4, LANE_W = 32, ROW_DW = 128.
- One sub-module, drain_post: a combinational per-lane transform (ReLU or pass-through) from 128 bits to 128 bits, containing the macro guard.

## Test plan
- base_addr=0x1000, stride=0x10, num_rows=4, FIFO preloaded with 4 words, ready=1 -> writes to 0x1000/0x1010/0x1020/0x1030 with data in FIFO order; done exactly 13 cycles after start; FIFO ends empty.
- Same setup with ready low for 5 cycles on row 1 -> addr/data held stable while valid is high; no extra pops; all 4 rows written once.
- FIFO empty at start; one word pushed 10 cycles later, num_rows=1 -> rd_en stays low until buf_empty = 0; one write; done follows.
- base_addr=0xFFFF_FFF0, stride=0x10, num_rows=2 -> writes to 0xFFFF_FFF0 then 0x0000_0000.
- Lane data 0xFFFF_FFFF (-1), 5, 0x8000_0000, 7 -> written as 0,5,0,7 with ACUM_DRAIN_RELU_EN defined, unchanged without it. Separately, num_rows=0 -> done at t+1 with no pops or writes.
- Reset asserted during WRITE of row 2 -> all outputs return to reset values; a following start operates normally.
